exec_issue_ctrl: RTL and testbench

Issue controller between Decode and Execute. It holds a per-register scoreboard of in-flight destination writes and gates the Execute input-flop load (`ex_issue`) to block RAW hazards and cap the number of in-flight instructions. On a writeback-reported branch mispredict it flushes the Execute inputs and clears the scoreboard. Sits beside Execute; Decode's valid is handshaked through `dec_ready`.

---
 rtl/exec_ctrl_pkg.sv | 20 ++
 rtl/exec_issue_ctrl_reg_scoreboard.sv | 71 +++++++
 rtl/exec_issue_ctrl.sv | 165 ++++++++++++++++
 tb/tb_exec_issue_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the Decode->Execute issue controller.
//   e_issue_state : issue FSM states (RUN / FLUSH)
//   NUM_ARCH_REGS : number of architectural integer registers
//   REG_ZERO      : hard-wired zero register index
//   counted_reg() : true when a write to register r is tracked (x0 never is)
package exec_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } e_issue_state;

  localparam int         NUM_ARCH_REGS = 32;
  localparam logic [4:0] REG_ZERO      = 5'd0;

  function automatic logic counted_reg(input logic writes, input logic [4:0] r);
    return writes && (r != REG_ZERO);
  endfunction

endpackage

// File: rtl/exec_issue_ctrl_reg_scoreboard.sv
// reg_scoreboard: one pending-write counter per architectural register.
//   clk, rst        : clock, asynchronous active-high reset
//   clr             : zero every counter at the next edge (highest priority)
//   inc_en, inc_rd  : add one in-flight write to inc_rd
//   dec_en, dec_rd  : retire one in-flight write to dec_rd
//   rd_a/b, cnt_a/b : combinational read ports (registered counts)
//   dec_underflow   : dec_en aimed at a counter that is already zero
// Counters saturate at zero; x0 reads as a constant zero. The caller
// keeps the counts bounded by the in-flight cap, so no overflow check.
module reg_scoreboard
  import exec_ctrl_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc_en,
  input  logic [4:0]       inc_rd,
  input  logic             dec_en,
  input  logic [4:0]       dec_rd,
  input  logic [4:0]       rd_a,
  input  logic [4:0]       rd_b,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             dec_underflow
);

  logic [CNT_W-1:0] pend_cnt [NUM_ARCH_REGS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ARCH_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign pend_cnt[gi] = '0;
      end else begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             inc_hit, dec_hit;

        always_comb begin
          inc_hit = inc_en && (inc_rd == 5'(gi));
          // A decrement of an empty counter is dropped (saturate at zero).
          dec_hit = dec_en && (dec_rd == 5'(gi)) && (cnt_q != '0);
          cnt_d   = cnt_q;
          if (clr) begin
            cnt_d = '0;
          end else if (inc_hit && !dec_hit) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else if (dec_hit && !inc_hit) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        assign pend_cnt[gi] = cnt_q;
      end
    end
  endgenerate

  assign cnt_a         = pend_cnt[rd_a];
  assign cnt_b         = pend_cnt[rd_b];
  assign dec_underflow = dec_en && (dec_rd != REG_ZERO) && (pend_cnt[dec_rd] == '0);

endmodule

// File: rtl/exec_issue_ctrl.sv
// exec_issue_ctrl: gates the Execute input-flop load against RAW hazards
// and an in-flight cap, and flushes Execute on a retired mispredict.
//   clk, rst                      : clock, asynchronous active-high reset
//   dec_valid / dec_ready         : Decode handshake
//   dec_rs1/rs2, dec_uses_rs1/rs2 : source registers and whether they are read
//   dec_rd, dec_writes_rd         : destination register
//   ex_issue                      : Execute input-flop load enable
//   ex_flush                      : Execute treats its flopped instruction as a bubble
//   wb_valid, wb_rd, wb_writes_rd : retirement report
//   wb_mispredict                 : retiring branch mispredicted (qualified by wb_valid)
//   inflight                      : issued-but-not-retired count
//   stall_cycles                  : saturating count of cycles Decode was held off
//   err_underflow                 : sticky retire-without-matching-issue error
module exec_issue_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_uses_rs1,
  input  logic             dec_uses_rs2,
  input  logic [4:0]       dec_rd,
  input  logic             dec_writes_rd,
  output logic             ex_issue,
  output logic             ex_flush,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic             wb_writes_rd,
  input  logic             wb_mispredict,
  output logic [CNT_W-1:0] inflight,
  output logic [31:0]      stall_cycles,
  output logic             err_underflow
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  e_issue_state     state_q, state_d;
  logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic             ex_flush_q, ex_flush_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [31:0]      stall_q, stall_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] pend_rs1, pend_rs2;
  logic             in_run, mispredict, retire;
  logic             hz1, hz2, full;
  logic             sb_inc, sb_dec, sb_clr, sb_underflow;

  // Hazards look only at registered counts: a retirement in this cycle
  // does not release a waiting consumer until the following cycle.
  always_comb begin
    in_run     = (state_q == RUN);
    mispredict = in_run && wb_valid && wb_mispredict;
    retire     = in_run && wb_valid && !wb_mispredict;
    hz1        = dec_uses_rs1 && (dec_rs1 != REG_ZERO) && (pend_rs1 != '0);
    hz2        = dec_uses_rs2 && (dec_rs2 != REG_ZERO) && (pend_rs2 != '0);
    full       = (inflight_q == CNT_W'(MAX_INFLIGHT));
    dec_ready  = in_run && !hz1 && !hz2 && !full && !(wb_valid && wb_mispredict);
    ex_issue   = dec_valid && dec_ready;
    sb_inc     = ex_issue && counted_reg(dec_writes_rd, dec_rd);
    sb_dec     = retire && counted_reg(wb_writes_rd, wb_rd);
    // Everything younger than a mispredicted branch is dead.
    sb_clr     = mispredict;
  end

  reg_scoreboard #(
    .CNT_W (CNT_W)
  ) u_sb (
    .clk           (clk),
    .rst           (rst),
    .clr           (sb_clr),
    .inc_en        (sb_inc),
    .inc_rd        (dec_rd),
    .dec_en        (sb_dec),
    .dec_rd        (wb_rd),
    .rd_a          (dec_rs1),
    .rd_b          (dec_rs2),
    .cnt_a         (pend_rs1),
    .cnt_b         (pend_rs2),
    .dec_underflow (sb_underflow)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    ex_flush_d  = ex_flush_q;
    case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d     = FLUSH;
          flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
          ex_flush_d  = 1'b1;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == '0) begin
          state_d    = RUN;
          ex_flush_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q - FC_W'(1);
        end
      end
      default: begin
        state_d     = RUN;
        flush_cnt_d = '0;
        ex_flush_d  = 1'b0;
      end
    endcase
  end

  // Issue and retire in the same cycle cancel; a retire with nothing in
  // flight is dropped and flagged instead of wrapping.
  always_comb begin
    inflight_d = inflight_q;
    if (mispredict) begin
      inflight_d = '0;
    end else begin
      if (ex_issue) begin
        inflight_d = inflight_d + CNT_W'(1);
      end
      if (retire && (inflight_q != '0)) begin
        inflight_d = inflight_d - CNT_W'(1);
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (dec_valid && !dec_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
    err_d = err_q || (in_run && wb_valid && (inflight_q == '0)) || sb_underflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      ex_flush_q  <= 1'b0;
      inflight_q  <= '0;
      stall_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      ex_flush_q  <= ex_flush_d;
      inflight_q  <= inflight_d;
      stall_q     <= stall_d;
      err_q       <= err_d;
    end
  end

  assign ex_flush      = ex_flush_q;
  assign inflight      = inflight_q;
  assign stall_cycles  = stall_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_exec_issue_ctrl.sv
module tb_exec_issue_ctrl;

  localparam int MAXI = 4;
  localparam int FC   = 2;
  localparam int CW   = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dec_valid, dec_ready;
  logic [4:0]    dec_rs1, dec_rs2, dec_rd;
  logic          dec_uses_rs1, dec_uses_rs2, dec_writes_rd;
  logic          ex_issue, ex_flush;
  logic          wb_valid, wb_writes_rd, wb_mispredict;
  logic [4:0]    wb_rd;
  logic [CW-1:0] inflight;
  logic [31:0]   stall_cycles;
  logic          err_underflow;

  int n_cmp = 0;
  int n_bad = 0;

  exec_issue_ctrl #(.MAX_INFLIGHT(MAXI), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .dec_rd(dec_rd), .dec_writes_rd(dec_writes_rd),
    .ex_issue(ex_issue), .ex_flush(ex_flush),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_writes_rd(wb_writes_rd),
    .wb_mispredict(wb_mispredict),
    .inflight(inflight), .stall_cycles(stall_cycles), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (in-order pipeline view) ----------------
  typedef struct {logic w; logic [4:0] rd;} ent_t;
  ent_t   q[$];
  int     m_pend [32];
  int     m_inflight;
  bit     m_flush;
  int     m_left;
  longint m_stall;
  bit     m_err;

  function automatic bit exp_ready_f();
    if (m_flush) return 1'b0;
    if (wb_valid && wb_mispredict) return 1'b0;
    if (m_inflight == MAXI) return 1'b0;
    if (dec_uses_rs1 && dec_rs1 != 0 && m_pend[dec_rs1] != 0) return 1'b0;
    if (dec_uses_rs2 && dec_rs2 != 0 && m_pend[dec_rs2] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 0;
    q.delete();
    m_inflight = 0; m_flush = 0; m_left = 0; m_stall = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit rdy, iss;
    int old_wb;
    rdy = exp_ready_f();
    iss = dec_valid && rdy;
    if (dec_valid && !rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (m_flush) begin
      if (m_left == 0) m_flush = 0; else m_left--;
    end else if (wb_valid && wb_mispredict) begin
      if (m_inflight == 0) m_err = 1;
      foreach (m_pend[i]) m_pend[i] = 0;
      m_inflight = 0;
      q.delete();
      m_flush = 1;
      m_left  = FC - 1;
    end else begin
      old_wb = m_pend[wb_rd];
      if (wb_valid && m_inflight == 0) m_err = 1;
      if (wb_valid && wb_writes_rd && wb_rd != 0 && old_wb == 0) m_err = 1;
      if (iss && dec_writes_rd && dec_rd != 0) m_pend[dec_rd]++;
      if (wb_valid && wb_writes_rd && wb_rd != 0 && old_wb > 0) m_pend[wb_rd]--;
      if (wb_valid && m_inflight > 0) m_inflight--;
      if (iss) m_inflight++;
      if (wb_valid && q.size() > 0) void'(q.pop_front());
      if (iss) q.push_back('{dec_writes_rd, dec_rd});
    end
  endtask

  // ---------------- stimulus helpers (no comparisons) ----------------
  task automatic idle();
    dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_uses_rs1 = 0; dec_uses_rs2 = 0;
    dec_rd = 0; dec_writes_rd = 0;
    wb_valid = 0; wb_rd = 0; wb_writes_rd = 0; wb_mispredict = 0;
  endtask

  task automatic issue_in(input logic [4:0] rd);
    idle();
    dec_valid = 1; dec_rd = rd; dec_writes_rd = 1;
  endtask

  task automatic apply_reset();
    idle();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    #1;
    n_cmp++; if (dec_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", dec_ready); end
    n_cmp++; if (ex_flush !== 1'b0) begin n_bad++; $display("FAIL reset_flush: got %b want 0", ex_flush); end
    n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
    n_cmp++; if (err_underflow !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err_underflow); end
    $display("txn reset: ready=%b inflight=%0d", dec_ready, inflight);
  endtask

  task automatic test_basic_issue();
    apply_reset();
    issue_in(5'd3);
    dec_rs1 = 5'd1; dec_rs2 = 5'd2; dec_uses_rs1 = 1; dec_uses_rs2 = 1;
    #1;
    n_cmp++; if (ex_issue !== 1'b1) begin n_bad++; $display("FAIL basic_issue: got %b want 1", ex_issue); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (inflight !== 3'd1) begin n_bad++; $display("FAIL basic_inflight: got %0d want 1", inflight); end
    n_cmp++; if (int'(dut.u_sb.pend_cnt[3]) !== 1) begin n_bad++; $display("FAIL basic_pend3: got %0d want 1", dut.u_sb.pend_cnt[3]); end
    $display("txn basic_issue: inflight=%0d", inflight);
  endtask

  task automatic test_raw_stall();
    apply_reset();
    issue_in(5'd5);
    @(negedge clk);
    issue_in(5'd6); dec_rs1 = 5'd5; dec_uses_rs1 = 1;
    #1;
    n_cmp++; if (dec_ready !== 1'b0) begin n_bad++; $display("FAIL raw_ready: got %b want 0", dec_ready); end
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); #1;
      n_cmp++; if (stall_cycles !== 32'(k)) begin n_bad++; $display("FAIL raw_stall%0d: got %0d want %0d", k, stall_cycles, k); end
    end
    wb_valid = 1; wb_rd = 5'd5; wb_writes_rd = 1;
    #1;
    n_cmp++; if (dec_ready !== 1'b0) begin n_bad++; $display("FAIL raw_retire_cycle: got %b want 0", dec_ready); end
    @(negedge clk); wb_valid = 0; wb_writes_rd = 0; wb_rd = 0; #1;
    n_cmp++; if (ex_issue !== 1'b1) begin n_bad++; $display("FAIL raw_release: got %b want 1", ex_issue); end
    n_cmp++; if (stall_cycles !== 32'd4) begin n_bad++; $display("FAIL raw_stall_final: got %0d want 4", stall_cycles); end
    n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL raw_inflight: got %0d want 0", inflight); end
    $display("txn raw_stall: stalls=%0d", stall_cycles);
  endtask

  task automatic test_full();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      issue_in(5'(10 + i)); #1;
      n_cmp++; if (ex_issue !== 1'b1) begin n_bad++; $display("FAIL full_fill%0d: got %b want 1", i, ex_issue); end
      @(negedge clk);
    end
    issue_in(5'd20); #1;
    n_cmp++; if (inflight !== 3'd4) begin n_bad++; $display("FAIL full_count: got %0d want 4", inflight); end
    n_cmp++; if (dec_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", dec_ready); end
    wb_valid = 1; wb_rd = 5'd10; wb_writes_rd = 1; #1;
    n_cmp++; if (ex_issue !== 1'b0) begin n_bad++; $display("FAIL full_retire_noissue: got %b want 0", ex_issue); end
    @(negedge clk); wb_rd = 5'd11; #1;
    n_cmp++; if (ex_issue !== 1'b1) begin n_bad++; $display("FAIL full_swap_issue: got %b want 1", ex_issue); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (inflight !== 3'd3) begin n_bad++; $display("FAIL full_swap_count: got %0d want 3", inflight); end
    n_cmp++; if (int'(dut.u_sb.pend_cnt[20]) !== 1) begin n_bad++; $display("FAIL full_pend20: got %0d want 1", dut.u_sb.pend_cnt[20]); end
    n_cmp++; if (int'(dut.u_sb.pend_cnt[11]) !== 0) begin n_bad++; $display("FAIL full_pend11: got %0d want 0", dut.u_sb.pend_cnt[11]); end
    $display("txn full: inflight=%0d", inflight);
  endtask

  task automatic test_x0();
    apply_reset();
    issue_in(5'd0);
    @(negedge clk);
    issue_in(5'd0); dec_rs1 = 0; dec_uses_rs1 = 1; dec_rs2 = 0; dec_uses_rs2 = 1; #1;
    n_cmp++; if (dec_ready !== 1'b1) begin n_bad++; $display("FAIL x0_ready: got %b want 1", dec_ready); end
    n_cmp++; if (int'(dut.u_sb.pend_cnt[0]) !== 0) begin n_bad++; $display("FAIL x0_pend: got %0d want 0", dut.u_sb.pend_cnt[0]); end
    @(negedge clk); idle(); wb_valid = 1; wb_rd = 0; wb_writes_rd = 1;
    @(negedge clk); idle(); #1;
    n_cmp++; if (inflight !== 3'd1) begin n_bad++; $display("FAIL x0_inflight: got %0d want 1", inflight); end
    n_cmp++; if (err_underflow !== 1'b0) begin n_bad++; $display("FAIL x0_err: got %b want 0", err_underflow); end
    $display("txn x0: inflight=%0d", inflight);
  endtask

  task automatic test_mispredict();
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      issue_in(5'(i));
      @(negedge clk);
    end
    issue_in(5'd4); wb_valid = 1; wb_mispredict = 1; #1;
    n_cmp++; if (ex_issue !== 1'b0) begin n_bad++; $display("FAIL mp_noissue: got %b want 0", ex_issue); end
    @(negedge clk); wb_mispredict = 0; wb_rd = 5'd1; wb_writes_rd = 1; #1;
    n_cmp++; if (ex_flush !== 1'b1) begin n_bad++; $display("FAIL mp_flush1: got %b want 1", ex_flush); end
    n_cmp++; if (dec_ready !== 1'b0) begin n_bad++; $display("FAIL mp_ready1: got %b want 0", dec_ready); end
    n_cmp++; if (inflight !== 3'd0) begin n_bad++; $display("FAIL mp_inflight: got %0d want 0", inflight); end
    @(negedge clk); #1;
    n_cmp++; if (ex_flush !== 1'b1) begin n_bad++; $display("FAIL mp_flush2: got %b want 1", ex_flush); end
    n_cmp++; if (dec_ready !== 1'b0) begin n_bad++; $display("FAIL mp_ready2: got %b want 0", dec_ready); end
    @(negedge clk); wb_valid = 0; wb_writes_rd = 0; wb_rd = 0; #1;
    n_cmp++; if (ex_flush !== 1'b0) begin n_bad++; $display("FAIL mp_flush_end: got %b want 0", ex_flush); end
    n_cmp++; if (ex_issue !== 1'b1) begin n_bad++; $display("FAIL mp_resume: got %b want 1", ex_issue); end
    n_cmp++; if (err_underflow !== 1'b0) begin n_bad++; $display("FAIL mp_err: got %b want 0", err_underflow); end
    for (int r = 0; r < 32; r++) begin
      n_cmp++; if (int'(dut.u_sb.pend_cnt[r]) !== 0) begin n_bad++; $display("FAIL mp_pend%0d: got %0d want 0", r, dut.u_sb.pend_cnt[r]); end
    end
    @(negedge clk); idle();
    $display("txn mispredict: flush complete");
  endtask

  task automatic test_underflow_async_reset();
    apply_reset();
    wb_valid = 1;
    @(negedge clk); idle(); #1;
    n_cmp++; if (err_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_set: got %b want 1", err_underflow); end
    @(negedge clk);
    dec_valid = 1; wb_valid = 1; wb_mispredict = 1;
    @(negedge clk); wb_valid = 0; wb_mispredict = 0; #1;
    n_cmp++; if (err_underflow !== 1'b1) begin n_bad++; $display("FAIL uf_sticky: got %b want 1", err_underflow); end
    n_cmp++; if (ex_flush !== 1'b1) begin n_bad++; $display("FAIL uf_inflush: got %b want 1", ex_flush); end
    n_cmp++; if (stall_cycles !== 32'd1) begin n_bad++; $display("FAIL uf_stall: got %0d want 1", stall_cycles); end
    #2; rst = 1; #1;
    n_cmp++; if (ex_flush !== 1'b0) begin n_bad++; $display("FAIL arst_flush: got %b want 0", ex_flush); end
    n_cmp++; if (err_underflow !== 1'b0) begin n_bad++; $display("FAIL arst_err: got %b want 0", err_underflow); end
    n_cmp++; if (stall_cycles !== 32'd0) begin n_bad++; $display("FAIL arst_stall: got %0d want 0", stall_cycles); end
    n_cmp++; if (dec_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready: got %b want 1", dec_ready); end
    @(negedge clk); rst = 0; idle();
    $display("txn underflow_async_reset: err=%b", err_underflow);
  endtask

  task automatic test_random();
    bit er;
    apply_reset();
    model_reset();
    for (int c = 0; c < 2000; c++) begin
      idle();
      dec_valid     = ($urandom_range(0, 9) < 7);
      dec_rs1       = 5'($urandom_range(0, 7));
      dec_rs2       = 5'($urandom_range(0, 7));
      dec_uses_rs1  = 1'($urandom_range(0, 1));
      dec_uses_rs2  = 1'($urandom_range(0, 1));
      dec_rd        = 5'($urandom_range(0, 7));
      dec_writes_rd = ($urandom_range(0, 3) != 0);
      if (m_flush) begin
        wb_valid      = 1'($urandom_range(0, 1));
        wb_rd         = 5'($urandom_range(0, 7));
        wb_writes_rd  = 1'($urandom_range(0, 1));
        wb_mispredict = 1'($urandom_range(0, 1));
      end else if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        wb_valid      = 1;
        wb_rd         = q[0].rd;
        wb_writes_rd  = q[0].w;
        wb_mispredict = ($urandom_range(0, 15) == 0);
      end else if (q.size() == 0 && $urandom_range(0, 299) == 0) begin
        wb_valid     = 1;
        wb_rd        = 5'($urandom_range(0, 7));
        wb_writes_rd = 1'($urandom_range(0, 1));
      end
      #1;
      er = exp_ready_f();
      n_cmp++; if (dec_ready !== er) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, dec_ready, er); end
      n_cmp++; if (ex_issue !== (dec_valid && er)) begin n_bad++; $display("FAIL rnd_issue c%0d: got %b want %b", c, ex_issue, dec_valid && er); end
      n_cmp++; if (ex_flush !== m_flush) begin n_bad++; $display("FAIL rnd_flush c%0d: got %b want %b", c, ex_flush, m_flush); end
      n_cmp++; if (int'(inflight) !== m_inflight) begin n_bad++; $display("FAIL rnd_inflight c%0d: got %0d want %0d", c, inflight, m_inflight); end
      n_cmp++; if (stall_cycles !== 32'(m_stall)) begin n_bad++; $display("FAIL rnd_stall c%0d: got %0d want %0d", c, stall_cycles, m_stall); end
      n_cmp++; if (err_underflow !== m_err) begin n_bad++; $display("FAIL rnd_err c%0d: got %b want %b", c, err_underflow, m_err); end
      if (c % 8 == 0) begin
        for (int r = 0; r < 8; r++) begin
          n_cmp++; if (int'(dut.u_sb.pend_cnt[r]) !== m_pend[r]) begin n_bad++; $display("FAIL rnd_pend%0d c%0d: got %0d want %0d", r, c, dut.u_sb.pend_cnt[r], m_pend[r]); end
        end
      end
      if (c % 250 == 0)
        $display("txn random c%0d: inflight=%0d stall=%0d flush=%b", c, inflight, stall_cycles, ex_flush);
      model_step();
      @(negedge clk);
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_basic_issue();
    test_raw_stall();
    test_full();
    test_x0();
    test_mispredict();
    test_underflow_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
